logic_unit_pipe: RTL and testbench

- Parametrised, pipelined bitwise logic unit for the ALU datapath. It generalises the fixed 32-bit AND gate to WIDTH bits.
- Operations: AND, OR, XOR, NOR, ANDN and PASSA, selected by opcode.
- Results pass through STAGES register stages with valid/ready flow control.
- Each result carries a zero flag, an illegal-opcode flag and a caller tag, so the execute stage can stall it without losing data.

---
 rtl/alu_pkg.sv | 18 +
 rtl/logic_pipe_stage.sv | 31 +++
 rtl/logic_unit_pipe.sv | 92 +++++++++
 tb/tb_logic_unit_pipe.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings used by the bitwise logic unit
// and any execute-stage logic that issues operations to it.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;

  localparam logic [ALU_OP_W-1:0] OP_AND   = 3'b000;
  localparam logic [ALU_OP_W-1:0] OP_OR    = 3'b001;
  localparam logic [ALU_OP_W-1:0] OP_XOR   = 3'b010;
  localparam logic [ALU_OP_W-1:0] OP_NOR   = 3'b011;
  localparam logic [ALU_OP_W-1:0] OP_ANDN  = 3'b100;
  localparam logic [ALU_OP_W-1:0] OP_PASSA = 3'b101;

  function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op);
    return op <= OP_PASSA;
  endfunction

endpackage

// File: rtl/logic_pipe_stage.sv
// One pipeline slot: a valid bit plus payload, loaded from upstream when the
// stage is allowed to advance and held otherwise.
module logic_pipe_stage #(
  parameter int unsigned PAYLOAD_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_load,
  input  logic                 i_valid,
  input  logic [PAYLOAD_W-1:0] i_data,
  output logic                 o_valid,
  output logic [PAYLOAD_W-1:0] o_data
);

  logic                 r_valid;
  logic [PAYLOAD_W-1:0] r_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined WIDTH-bit bitwise logic unit with valid/ready flow control; each
// result travels with its zero flag, illegal-opcode flag and caller tag.
module logic_unit_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ALU_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]    in_a,
  input  logic [WIDTH-1:0]    in_b,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_result,
  output logic                out_zero,
  output logic                out_illegal,
  output logic [TAG_W-1:0]    out_tag
);

  localparam int unsigned PAYLOAD_W = WIDTH + 2 + TAG_W;

  logic [WIDTH-1:0] w_result;
  logic             w_illegal;
  logic             w_zero;

  always_comb begin
    w_result  = '0;
    w_illegal = 1'b0;
    case (in_op)
      OP_AND:   w_result = in_a & in_b;
      OP_OR:    w_result = in_a | in_b;
      OP_XOR:   w_result = in_a ^ in_b;
      OP_NOR:   w_result = ~(in_a | in_b);
      OP_ANDN:  w_result = in_a & ~in_b;
      OP_PASSA: w_result = in_a;
      default:  w_illegal = 1'b1;
    endcase
  end

  assign w_zero = (w_result == '0);

  logic [STAGES-1:0]    w_valid;
  logic [STAGES-1:0]    w_adv;
  logic [PAYLOAD_W-1:0] w_data [STAGES];

  // Ready ripples back from the consumer; an empty stage always advances,
  // so bubbles collapse and a full pipe still accepts when the tail retires.
  always_comb begin
    w_adv = '0;
    w_adv[STAGES-1] = !w_valid[STAGES-1] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      w_adv[k] = !w_valid[k] || w_adv[k+1];
    end
  end

  assign in_ready = w_adv[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic                 w_up_valid;
    logic [PAYLOAD_W-1:0] w_up_data;

    if (k == 0) begin : g_head
      assign w_up_valid = in_valid;
      assign w_up_data  = {w_result, w_zero, w_illegal, in_tag};
    end else begin : g_body
      assign w_up_valid = w_valid[k-1];
      assign w_up_data  = w_data[k-1];
    end

    logic_pipe_stage #(
      .PAYLOAD_W(PAYLOAD_W)
    ) u_stage (
      .clock  (clock),
      .reset  (reset),
      .i_load (w_adv[k]),
      .i_valid(w_up_valid),
      .i_data (w_up_data),
      .o_valid(w_valid[k]),
      .o_data (w_data[k])
    );
  end

  assign out_valid = w_valid[STAGES-1];
  assign {out_result, out_zero, out_illegal, out_tag} = w_data[STAGES-1];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed checks on a 32-bit/2-stage unit plus
// randomized traffic on three configurations against an in-order scoreboard.
module tb_logic_unit_pipe;

  localparam int NCFG = 3;

  typedef struct packed {
    logic [63:0] res;
    logic        zero;
    logic        ill;
    logic [3:0]  tag;
    logic [31:0] acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_errors = 0;
  logic done = 1'b0;

  logic [NCFG-1:0]        rst_v;
  logic [NCFG-1:0]        in_valid_v;
  logic [NCFG-1:0]        out_ready_v;
  logic [NCFG-1:0][2:0]   in_op_v;
  logic [NCFG-1:0][63:0]  in_a_v;
  logic [NCFG-1:0][63:0]  in_b_v;
  logic [NCFG-1:0][3:0]   in_tag_v;
  logic [NCFG-1:0]        in_ready_v;
  logic [NCFG-1:0]        out_valid_v;
  logic [NCFG-1:0]        out_zero_v;
  logic [NCFG-1:0]        out_ill_v;
  logic [NCFG-1:0][63:0]  out_res_v;
  logic [NCFG-1:0][3:0]   out_tag_v;

  logic [31:0] op_exp [6];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Golden behaviour: opcode table applied to operands truncated to w bits.
  function automatic exp_t model(input logic [2:0] op, input logic [63:0] a,
                                 input logic [63:0] b, input logic [3:0] tag,
                                 input int w, input int acc);
    logic [63:0] mask;
    logic [63:0] r;
    logic        ill;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    ill  = 1'b0;
    case (op)
      3'd0:    r = a & b;
      3'd1:    r = a | b;
      3'd2:    r = a ^ b;
      3'd3:    r = ~(a | b);
      3'd4:    r = a & ~b;
      3'd5:    r = a;
      default: begin r = '0; ill = 1'b1; end
    endcase
    r = r & mask;
    return '{res: r, zero: (r == 64'd0), ill: ill, tag: tag, acc: 32'(acc)};
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int unsigned W = (g == 0) ? 32 : (g == 1) ? 8 : 64;
    localparam int unsigned S = (g == 0) ? 2 : (g == 1) ? 1 : 4;

    logic [W-1:0] res_w;
    exp_t         q[$];
    exp_t         e;
    int           last_stall = -1;
    bit           head_seen = 1'b0;
    bit           drained = 1'b0;

    logic_unit_pipe #(
      .WIDTH (W),
      .STAGES(S),
      .TAG_W (4)
    ) u_dut (
      .clock      (clk),
      .reset      (rst_v[g]),
      .in_valid   (in_valid_v[g]),
      .in_ready   (in_ready_v[g]),
      .in_op      (in_op_v[g]),
      .in_a       (in_a_v[g][W-1:0]),
      .in_b       (in_b_v[g][W-1:0]),
      .in_tag     (in_tag_v[g]),
      .out_valid  (out_valid_v[g]),
      .out_ready  (out_ready_v[g]),
      .out_result (res_w),
      .out_zero   (out_zero_v[g]),
      .out_illegal(out_ill_v[g]),
      .out_tag    (out_tag_v[g])
    );

    assign out_res_v[g] = 64'(res_w);

    initial forever begin
      @(negedge clk);
      if (rst_v[g]) begin
        q.delete();
        head_seen = 1'b0;
      end else begin
        if (out_valid_v[g]) begin
          check($sformatf("cfg%0d_not_spurious", g), 64'(q.size() > 0), 64'd1);
          if (q.size() > 0) begin
            if (!head_seen) begin
              head_seen = 1'b1;
              if (last_stall < int'(q[0].acc))
                check($sformatf("cfg%0d_latency", g), 64'(cyc - int'(q[0].acc)), 64'(S));
              else
                check($sformatf("cfg%0d_latency_min", g),
                      64'((cyc - int'(q[0].acc)) >= int'(S)), 64'd1);
            end
            if (out_ready_v[g]) begin
              e = q.pop_front();
              check($sformatf("cfg%0d_result", g), out_res_v[g], e.res);
              check($sformatf("cfg%0d_flags_tag", g),
                    64'({out_zero_v[g], out_ill_v[g], out_tag_v[g]}),
                    64'({e.zero, e.ill, e.tag}));
              head_seen = 1'b0;
            end else begin
              last_stall = cyc;
            end
          end
        end
        if (in_valid_v[g] && in_ready_v[g])
          q.push_back(model(in_op_v[g], in_a_v[g], in_b_v[g], in_tag_v[g], int'(W), cyc));
        if (done && !drained) begin
          drained = 1'b1;
          check($sformatf("cfg%0d_drained", g), 64'(q.size()), 64'd0);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [3:0] tag);
    in_valid_v[0] = v;
    in_op_v[0]    = op;
    in_a_v[0]     = a;
    in_b_v[0]     = b;
    in_tag_v[0]   = tag;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 64'(out_valid_v[0]), 64'd0);
    check({tag, "_result"}, out_res_v[0], 64'd0);
    check({tag, "_zero_ill_tag"}, 64'({out_zero_v[0], out_ill_v[0], out_tag_v[0]}), 64'd0);
  endtask

  initial begin
    logic [63:0] pa;
    logic [63:0] pb;
    logic [63:0] bp_exp;

    op_exp = '{32'hF000_F000, 32'hFFF0_FFF0, 32'h0FF0_0FF0,
               32'h000F_000F, 32'h00F0_00F0, 32'hF0F0_F0F0};
    rst_v       = '1;
    in_valid_v  = '0;
    out_ready_v = '1;
    in_op_v     = '0;
    in_a_v      = '0;
    in_b_v      = '0;
    in_tag_v    = '0;
    repeat (2) @(posedge clk);
    #1 rst_v = '0;
    #1;
    check_cleared("reset");
    check("reset_in_ready", 64'(in_ready_v[0]), 64'd1);

    // All six legal opcodes back-to-back
    for (int t = 0; t < 8; t++) begin
      if (t < 6) drive0(1'b1, 3'(t), 64'hF0F0_F0F0, 64'hFF00_FF00, 4'(t));
      else drive0(1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
      step();
      if (t >= 1 && t <= 6) begin
        check($sformatf("op%0d_valid", t - 1), 64'(out_valid_v[0]), 64'd1);
        check($sformatf("op%0d_result", t - 1), out_res_v[0], 64'(op_exp[t-1]));
        check($sformatf("op%0d_zero", t - 1), 64'(out_zero_v[0]), 64'd0);
        check($sformatf("op%0d_tag", t - 1), 64'(out_tag_v[0]), 64'(t - 1));
      end else if (t == 7) begin
        check("op_tail_idle", 64'(out_valid_v[0]), 64'd0);
      end
    end

    // Zero result and illegal opcode
    drive0(1'b1, 3'd0, 64'h0000_00FF, 64'hFFFF_FF00, 4'd6);
    step();
    drive0(1'b1, 3'd6, 64'h1234_5678, 64'h9ABC_DEF0, 4'd7);
    step();
    check("zero_valid", 64'(out_valid_v[0]), 64'd1);
    check("zero_result", out_res_v[0], 64'd0);
    check("zero_flags_tag", 64'({out_zero_v[0], out_ill_v[0], out_tag_v[0]}),
          64'({1'b1, 1'b0, 4'd6}));
    drive0(1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    step();
    check("ill_result", out_res_v[0], 64'd0);
    check("ill_flags_tag", 64'({out_zero_v[0], out_ill_v[0], out_tag_v[0]}),
          64'({1'b1, 1'b1, 4'd7}));
    step();

    // Backpressure: two held, third waits at the input
    pa = 64'h1234_5678;
    pb = 64'h0F0F_0F0F;
    bp_exp = model(3'd1, pa, pb, 4'd1, 32, 0).res;
    out_ready_v[0] = 1'b0;
    drive0(1'b1, 3'd1, pa, pb, 4'd1);
    step();
    drive0(1'b1, 3'd1, pa, pb, 4'd2);
    #1 check("bp_ready_one_held", 64'(in_ready_v[0]), 64'd1);
    step();
    drive0(1'b1, 3'd1, pa, pb, 4'd3);
    #1 check("bp_ready_full", 64'(in_ready_v[0]), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_stall_ready", 64'(in_ready_v[0]), 64'd0);
      check("bp_stall_valid", 64'(out_valid_v[0]), 64'd1);
      check("bp_stall_tag", 64'(out_tag_v[0]), 64'd1);
      check("bp_stall_result", out_res_v[0], bp_exp);
      check("bp_stall_flags", 64'({out_zero_v[0], out_ill_v[0]}), 64'd0);
    end
    out_ready_v[0] = 1'b1;
    #1 check("bp_release_ready", 64'(in_ready_v[0]), 64'd1);
    step();
    drive0(1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    check("bp_tag2", 64'({out_valid_v[0], out_tag_v[0]}), 64'({1'b1, 4'd2}));
    step();
    check("bp_tag3", 64'({out_valid_v[0], out_tag_v[0]}), 64'({1'b1, 4'd3}));
    step();
    check("bp_empty", 64'(out_valid_v[0]), 64'd0);

    // Full pipe with the consumer ready: accept and retire every cycle
    out_ready_v[0] = 1'b0;
    drive0(1'b1, 3'd2, pa, pb, 4'd0);
    step();
    drive0(1'b1, 3'd2, pa, pb, 4'd1);
    step();
    out_ready_v[0] = 1'b1;
    for (int k = 2; k < 10; k++) begin
      drive0(1'b1, 3'd2, pa, pb, 4'(k));
      #1;
      check($sformatf("pt_ready_%0d", k), 64'(in_ready_v[0]), 64'd1);
      check($sformatf("pt_out_%0d", k - 2), 64'({out_valid_v[0], out_tag_v[0]}),
            64'({1'b1, 4'(k - 2)}));
      step();
    end
    drive0(1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    check("pt_out_8", 64'({out_valid_v[0], out_tag_v[0]}), 64'({1'b1, 4'd8}));
    step();
    check("pt_out_9", 64'({out_valid_v[0], out_tag_v[0]}), 64'({1'b1, 4'd9}));
    step();

    // Reset with two operations in flight
    drive0(1'b1, 3'd4, 64'hFFFF_FFFF, 64'h0, 4'd10);
    step();
    drive0(1'b1, 3'd7, pa, pb, 4'd11);
    step();
    check("rmf_inflight", 64'(out_valid_v[0]), 64'd1);
    rst_v[0] = 1'b1;
    drive0(1'b1, 3'd5, pa, pb, 4'd12);
    step();
    rst_v[0] = 1'b0;
    drive0(1'b0, 3'd0, 64'd0, 64'd0, 4'd0);
    check_cleared("rmf");
    for (int i = 0; i < 4; i++) begin
      step();
      check("rmf_no_stale", 64'(out_valid_v[0]), 64'd0);
    end

    // Randomized traffic on every configuration
    for (int i = 0; i < 1500; i++) begin
      for (int g = 0; g < NCFG; g++) begin
        in_valid_v[g]  = ($urandom_range(0, 9) < 7);
        out_ready_v[g] = (((i / 100) % 3) == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        in_op_v[g]     = 3'($urandom_range(0, 7));
        in_a_v[g]      = {$urandom, $urandom};
        in_b_v[g]      = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) in_b_v[g] = in_a_v[g];
        if ($urandom_range(0, 15) == 0) in_a_v[g] = '0;
        in_tag_v[g]    = 4'($urandom);
      end
      step();
    end

    in_valid_v  = '0;
    out_ready_v = '1;
    repeat (12) step();
    done = 1'b1;
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
